// File: rtl/psum_pkg.sv
// Shared constants and types for the psum send/receive path (fan-out stage and adder).
package psum_pkg;
  localparam int unsigned PSUM_DWIDTH    = 8;
  localparam int unsigned NUM_LANES      = 3;
  // Adder datapath width; kept here so producer and consumer ends agree.
  localparam int unsigned PSUM_ADD_WIDTH = 8;

  typedef logic [PSUM_DWIDTH-1:0] psum_t;
  typedef logic [NUM_LANES-1:0]   lane_mask_t;
endpackage

// File: rtl/psum_lane_slot.sv
// One lane's pending bit: set on an upstream accept, cleared when the lane fires.
module psum_lane_slot
  import psum_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic set,
  input  logic ready,
  output logic pending,
  output logic fire,
  output logic free
);
  logic pending_q;

  assign pending = pending_q;
  assign fire    = pending_q & ready;
  // Lane will not block the next word: already delivered, or delivering now.
  assign free    = ~pending_q | ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= 1'b0;
    end else if (set) begin
      pending_q <= 1'b1;
    end else if (fire) begin
      pending_q <= 1'b0;
    end
  end
endmodule

// File: rtl/psum_fanout.sv
// Eager three-way fork of psum words. Define PSUM_FANOUT_CNT_EN to add the sent_count port.
module psum_fanout
  import psum_pkg::*;
#(
  parameter int unsigned DWIDTH    = psum_pkg::PSUM_DWIDTH,
  parameter int unsigned NUM_LANES = psum_pkg::NUM_LANES
`ifdef PSUM_FANOUT_CNT_EN
  ,
  parameter int unsigned CNT_WIDTH = 16
`endif
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DWIDTH-1:0]    in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [DWIDTH-1:0]    out_data,
  output logic [NUM_LANES-1:0] out_valid,
  input  logic [NUM_LANES-1:0] out_ready
`ifdef PSUM_FANOUT_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0] sent_count
`endif
);
  logic [DWIDTH-1:0]    data_q;
  logic [NUM_LANES-1:0] pending;
  logic [NUM_LANES-1:0] fire;
  logic [NUM_LANES-1:0] free;
  logic                 in_fire;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    psum_lane_slot u_slot (
      .clk     (clk),
      .rst_n   (rst_n),
      .set     (in_fire),
      .ready   (out_ready[i]),
      .pending (pending[i]),
      .fire    (fire[i]),
      .free    (free[i])
    );
  end

  assign in_ready  = &free;
  assign in_fire   = in_valid & in_ready;
  assign out_valid = pending;
  assign out_data  = data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else if (in_fire) begin
      data_q <= in_data;
    end
  end

`ifdef PSUM_FANOUT_CNT_EN
  logic [CNT_WIDTH-1:0] cnt_q;
  logic                 last_fire;

  // Holding a word and every remaining lane takes it this cycle.
  assign last_fire  = (|pending) & in_ready;
  assign sent_count = cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (last_fire) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end
`else
  logic unused_fire;
  assign unused_fire = ^fire;
`endif
endmodule

// File: tb/tb_psum_fanout.sv
// Directed self-checking bench for psum_fanout; counter checks only with PSUM_FANOUT_CNT_EN.
`timescale 1ns/1ps
module tb_psum_fanout;
  logic       clk;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic [2:0] out_valid;
  logic [2:0] out_ready;
`ifdef PSUM_FANOUT_CNT_EN
  logic [3:0] sent_count;
`endif

  int errors = 0;
  int checks = 0;
  int exp_cnt = 0;

  psum_fanout #(
    .DWIDTH    (8),
    .NUM_LANES (3)
`ifdef PSUM_FANOUT_CNT_EN
    ,
    .CNT_WIDTH (4)
`endif
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
`ifdef PSUM_FANOUT_CNT_EN
    ,
    .sent_count (sent_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to the next negedge (inputs change there), then let logic settle.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_data = 8'h00; in_valid = 1'b0; out_ready = 3'b000;
    #12;
    checks++;
    if (out_valid !== 3'b000) begin
      errors++; $display("FAIL reset_out_valid got=%b want=000", out_valid);
    end
    checks++;
    if (out_data !== 8'h00) begin
      errors++; $display("FAIL reset_out_data got=%h want=00", out_data);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready got=%b want=1", in_ready);
    end
`ifdef PSUM_FANOUT_CNT_EN
    checks++;
    if (sent_count !== 4'd0) begin
      errors++; $display("FAIL reset_sent_count got=%0d want=0", sent_count);
    end
`endif
    step();
    rst_n = 1'b1;
    exp_cnt = 0;
  endtask

  task automatic test_single();
    step();
    in_data = 8'h2A; in_valid = 1'b1; out_ready = 3'b111;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL single_in_ready got=%b want=1", in_ready);
    end
    step();
    in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 3'b111 || out_data !== 8'h2A) begin
      errors++;
      $display("FAIL single_present got=%b/%h want=111/2a", out_valid, out_data);
    end
    step();
    exp_cnt++;
    #1;
    checks++;
    if (out_valid !== 3'b000) begin
      errors++; $display("FAIL single_empty got=%b want=000", out_valid);
    end
`ifdef PSUM_FANOUT_CNT_EN
    checks++;
    if (sent_count !== 4'(exp_cnt)) begin
      errors++; $display("FAIL single_count got=%0d want=%0d", sent_count, exp_cnt % 16);
    end
`endif
  endtask

  task automatic test_staggered();
    logic [2:0] rdy_seq [3];
    logic [2:0] vld_seq [3];
    logic       irdy_seq [3];
    rdy_seq = '{3'b001, 3'b010, 3'b100};
    vld_seq = '{3'b111, 3'b110, 3'b100};
    irdy_seq = '{1'b0, 1'b0, 1'b1};
    step();
    in_data = 8'h05; in_valid = 1'b1; out_ready = 3'b000;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      out_ready = rdy_seq[i];
      #1;
      checks++;
      if (out_valid !== vld_seq[i] || out_data !== 8'h05) begin
        errors++;
        $display("FAIL stagger_valid[%0d] got=%b/%h want=%b/05", i, out_valid, out_data,
                 vld_seq[i]);
      end
      checks++;
      if (in_ready !== irdy_seq[i]) begin
        errors++;
        $display("FAIL stagger_in_ready[%0d] got=%b want=%b", i, in_ready, irdy_seq[i]);
      end
      step();
    end
    exp_cnt++;
    out_ready = 3'b000;
    #1;
    checks++;
    if (out_valid !== 3'b000 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL stagger_done got=%b/%b want=000/1", out_valid, in_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] words [3];
    words = '{8'h01, 8'h02, 8'h03};
    step();
    out_ready = 3'b111;
    for (int i = 0; i < 3; i++) begin
      in_data = words[i]; in_valid = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
        errors++; $display("FAIL b2b_in_ready[%0d] got=%b want=1", i, in_ready);
      end
      if (i > 0) begin
        checks++;
        if (out_valid !== 3'b111 || out_data !== words[i-1]) begin
          errors++;
          $display("FAIL b2b_word[%0d] got=%b/%h want=111/%h", i - 1, out_valid, out_data,
                   words[i-1]);
        end
      end
      step();
    end
    in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 3'b111 || out_data !== 8'h03) begin
      errors++; $display("FAIL b2b_word[2] got=%b/%h want=111/03", out_valid, out_data);
    end
    step();
    exp_cnt += 3;
    #1;
    checks++;
    if (out_valid !== 3'b000) begin
      errors++; $display("FAIL b2b_empty got=%b want=000", out_valid);
    end
`ifdef PSUM_FANOUT_CNT_EN
    checks++;
    if (sent_count !== 4'(exp_cnt)) begin
      errors++; $display("FAIL b2b_count got=%0d want=%0d", sent_count, exp_cnt % 16);
    end
`endif
  endtask

  task automatic test_stall();
    step();
    in_data = 8'h77; in_valid = 1'b1; out_ready = 3'b000;
    step();
    in_data = 8'hFF;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 3'b111 || out_data !== 8'h77) begin
        errors++;
        $display("FAIL stall[%0d] got=rdy%b/%b/%h want=rdy0/111/77", i, in_ready, out_valid,
                 out_data);
      end
      step();
    end
    // Release all lanes; the stalled word is taken in the same cycle.
    out_ready = 3'b111;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL stall_release_ready got=%b want=1", in_ready);
    end
    step();
    exp_cnt++;
    in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 3'b111 || out_data !== 8'hFF) begin
      errors++; $display("FAIL stall_next_word got=%b/%h want=111/ff", out_valid, out_data);
    end
    step();
    exp_cnt++;
    #1;
    checks++;
    if (out_valid !== 3'b000) begin
      errors++; $display("FAIL stall_no_double got=%b want=000", out_valid);
    end
`ifdef PSUM_FANOUT_CNT_EN
    checks++;
    if (sent_count !== 4'(exp_cnt)) begin
      errors++; $display("FAIL stall_count got=%0d want=%0d", sent_count, exp_cnt % 16);
    end
`endif
  endtask

  task automatic test_reset_mid();
    step();
    in_data = 8'hAA; in_valid = 1'b1; out_ready = 3'b000;
    step();
    in_valid = 1'b0; out_ready = 3'b010;
    step();
    out_ready = 3'b000;
    #1;
    checks++;
    if (out_valid !== 3'b101) begin
      errors++; $display("FAIL mid_pending got=%b want=101", out_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    exp_cnt = 0;
    checks++;
    if (out_valid !== 3'b000 || in_ready !== 1'b1 || out_data !== 8'h00) begin
      errors++;
      $display("FAIL mid_reset got=%b/rdy%b/%h want=000/rdy1/00", out_valid, in_ready, out_data);
    end
`ifdef PSUM_FANOUT_CNT_EN
    checks++;
    if (sent_count !== 4'd0) begin
      errors++; $display("FAIL mid_reset_count got=%0d want=0", sent_count);
    end
`endif
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_wrap();
    step();
    out_ready = 3'b111;
    for (int i = 0; i < 17; i++) begin
      in_data = 8'(i + 8'h10); in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    #1;
    checks++;
    if (out_data !== 8'h20 || out_valid !== 3'b111) begin
      errors++; $display("FAIL wrap_last_word got=%b/%h want=111/20", out_valid, out_data);
    end
    step();
    exp_cnt += 17;
    #1;
    checks++;
    if (out_valid !== 3'b000) begin
      errors++; $display("FAIL wrap_empty got=%b want=000", out_valid);
    end
`ifdef PSUM_FANOUT_CNT_EN
    checks++;
    if (sent_count !== 4'd1) begin
      errors++; $display("FAIL wrap_count got=%0d want=1", sent_count);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_single();
    test_staggered();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/psum_fanout.md
# psum_fanout

Clocked three-way broadcast stage for partial-sum words. It is the send-side counterpart of the psum adder: it takes one word from a single upstream producer and delivers the same word to three PE-side consumers, each on its own valid/ready channel. Each lane accepts independently (eager fork), and the next word is taken only after all three lanes have accepted the current one. It sits between the psum/ifmap source and the three PE input ports of a PE row.

## Interface
- DWIDTH, 8, width of the data word
- NUM_LANES, 3, number of consumer lanes; fixed at 3 in this revision
- CNT_WIDTH, 16, width of the delivered-word counter (counter feature only)
- clk  input  1  single clock; all state updates on the rising edge
- rst_n  input  1  reset, asynchronous assert, active-low
- in_data  input  DWIDTH  upstream word
- in_valid  input  1  upstream word valid
- in_ready  output  1  stage can take in_data this cycle
- out_data  output  DWIDTH  held word, shared by all lanes
- out_valid  output  NUM_LANES  per-lane word available
- out_ready  input  NUM_LANES  per-lane consumer ready
- sent_count  output  CNT_WIDTH  number of words fully delivered to all lanes (PSUM_FANOUT_CNT_EN only)

## Operation
- State is a data register and a pending[2:0] mask. States: EMPTY (pending==0) and HOLD (pending!=0).
- out_valid = pending. out_data = data register.
- Lane i fires when out_valid[i] && out_ready[i]. On a fire, pending[i] clears at the next edge.
- in_ready = &(~pending | out_ready). The stage is ready when it is empty, or when every still-pending lane fires this cycle.
- Input fire (in_valid && in_ready): the data register loads in_data and pending becomes 3'b111. This overrides any clears in the same cycle.
- EMPTY→HOLD on an input fire. HOLD→EMPTY when the last pending lanes fire and there is no input fire. HOLD→HOLD with a new word when the last lanes fire and an input fire happens in the same cycle.
- Lanes are never re-presented with a word they have already accepted. out_valid[i] never drops without a fire on lane i, except at reset.
- out_data is stable while any out_valid bit is high.
- in_valid with in_ready low stalls the upstream; it does not drop the word. Upstream must hold in_data stable until the fire.
- Reset mid-operation: pending clears immediately and the held word is discarded; partial deliveries are not completed.

## Timing
- Reset values: out_valid=3'b000, out_data=0, in_ready=1, sent_count=0.
- Latency: a word accepted at edge N is presented on all out_valid bits in the cycle after edge N.
- Throughput: 1 word/cycle when all out_ready bits are held high.
- in_ready is combinational from out_ready. There is no combinational path from in_valid to any output.
- Lane acceptance order is arbitrary. Lanes may fire in the same cycle or in different cycles.

## Configuration
- PSUM_FANOUT_CNT_EN defined: sent_count is present.
  - Increments by 1 on each cycle where the final pending lane(s) fire.
  - Wraps modulo 2^CNT_WIDTH.
  - Resets to 0.
- Not defined: the sent_count port and counter logic are absent. All other behaviour is identical.

## Structure
- Shared package psum_pkg holds:
  - default DWIDTH constant
  - NUM_LANES = 3
  - typedef psum_t (logic [DWIDTH-1:0])
  - typedef lane_mask_t (logic [NUM_LANES-1:0])
  - the adder's datapath width constant, so both ends agree
- Sub-module psum_lane_slot: one pending bit with set/clear and fire output, instantiated NUM_LANES times. The top holds the data register, in_ready reduction and the optional counter.

## Test plan
- Reset, then in_data=8'h2A with in_valid for 1 cycle and all out_ready=1 → out_valid=3'b111 and out_data=8'h2A the next cycle; EMPTY the cycle after; sent_count=1.
- Staggered accept: word 8'h05 loaded, then out_ready=001, then 010, then 100 on successive cycles → out_valid steps 111→110→100→000; in_ready=0 until the cycle lane 2 fires.
- Back-to-back: 8'h01, 8'h02, 8'h03 on consecutive cycles with all out_ready=1 → one word per cycle on out_data; in_ready stays 1; sent_count=3.
- Stall: out_ready=000 for 5 cycles with in_valid=1 and in_data=8'hFF pending → in_ready=0; out_data holds the prior word; no lane double-fires.
- Reset mid-HOLD: pending=3'b101, then rst_n low asynchronously → out_valid=000 immediately; in_ready=1; sent_count=0.
- Counter wrap (PSUM_FANOUT_CNT_EN, CNT_WIDTH=4): 17 full deliveries → sent_count=1.
